param_loader: RTL and testbench

Command-frame decoder and parameter register file for the pulse generator. Consumes the byte stream from the UART receiver and assembles checksummed 7-byte frames into the timing parameters used by the pulse sequencer: period, pulse widths, delay, nutation, CPMG count, blocking and pump flags. Raises a one-cycle `rxd` strobe on every committed write so the sequencer can reload on a clean boundary. Runs in the `clk` (12 MHz) domain.

---
 rtl/param_loader_if.sv | 32 +++
 rtl/param_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_param_loader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_loader_if.sv
// -----------------------------------------------------------------------------
// param_loader_if
//
// Byte-stream link from the UART receiver into the parameter loader.
//
// Handshake: the producer presents a byte on rx_data and holds rx_valid high
// for exactly one clk cycle per byte. There is no ready/backpressure. The
// consumer takes the byte on the clk edge where rx_valid is 1. rx_data is
// meaningless while rx_valid is 0.
//
// Signals:
//   rx_data   8  received byte
//   rx_valid  1  one-cycle strobe per received byte
//
// Modports:
//   master  byte producer (UART receiver / testbench driver)
//   slave   byte consumer (param_loader)
// -----------------------------------------------------------------------------
interface param_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (
        output rx_data,
        output rx_valid
    );

    modport slave (
        input rx_data,
        input rx_valid
    );
endinterface

// File: rtl/param_loader.sv
// -----------------------------------------------------------------------------
// param_loader
//
// Command-frame decoder and parameter register file for the pulse generator.
// It assembles checksummed 7-byte frames (SYNC, ADDR, D3, D2, D1, D0, CHK)
// from the UART byte stream. Each good frame writes exactly one timing
// register. The frame's CHK byte must equal the XOR of ADDR..D0.
//
// Parameters:
//   TIMEOUT_CYCLES  inter-byte gap (clk cycles) that aborts a partial frame
//   SYNC_BYTE       frame start marker
//
// Ports:
//   clk        in   system clock (12 MHz)
//   reset      in   asynchronous, active-high reset
//   rx         slave modport of param_loader_if (rx_data / rx_valid)
//   per        out  8   pulse period                  (addr 0x01)
//   p1wid      out  16  first pulse width             (addr 0x02)
//   del        out  16  inter-pulse delay             (addr 0x03)
//   p2wid      out  16  second pulse width            (addr 0x04)
//   nut_d      out  32  nutation delay                (addr 0x05)
//   nut_w      out  32  nutation width                (addr 0x06)
//   pu/nut/bl  out  1   pump / nutation / block flags (addr 0x07, D0[2:0])
//   cp         out  8   CPMG pulse count              (addr 0x08)
//   p_bl       out  8   pulse-block count             (addr 0x09)
//   p_bl_off   out  16  pulse-block off time          (addr 0x0A)
//   rxd        out  1   one-cycle strobe: a register was written
//   err        out  1   one-cycle strobe: a frame was rejected or timed out
//   state_dbg  out  2   current decoder state (HUNT=0, ADDR=1, DATA=2, CHK=3)
//
// All outputs are registered. The register write and rxd appear on the same
// edge that samples a good CHK byte.
// -----------------------------------------------------------------------------
module param_loader #(
    parameter int         TIMEOUT_CYCLES = 120000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic          clk,
    input  logic          reset,
    param_loader_if.slave rx,

    output logic [7:0]    per,
    output logic [15:0]   p1wid,
    output logic [15:0]   del,
    output logic [15:0]   p2wid,
    output logic [31:0]   nut_d,
    output logic [31:0]   nut_w,
    output logic          pu,
    output logic          nut,
    output logic          bl,
    output logic [7:0]    cp,
    output logic [7:0]    p_bl,
    output logic [15:0]   p_bl_off,
    output logic          rxd,
    output logic          err,
    output logic [1:0]    state_dbg
);

    // Timer only has to hold values up to TIMEOUT_CYCLES-1.
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_CHK  = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [7:0]    addr_r;
    logic [31:0]   data_buf;
    logic [7:0]    xor_r;
    logic [1:0]    byte_idx;
    logic [TW-1:0] timer;

    logic          addr_ok;
    logic          commit;
    logic          reject;
    logic          timeout;

    assign state_dbg = state;
    assign addr_ok   = (addr_r >= 8'h01) && (addr_r <= 8'h0A);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_HUNT;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and frame decision
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        commit     = 1'b0;
        reject     = 1'b0;
        // A byte arriving in the expiry cycle takes priority: the gap was
        // not exceeded, so the frame continues and no error is raised.
        timeout    = (state != S_HUNT) && !rx.rx_valid && (timer == TIMER_LAST);

        case (state)
            S_HUNT: begin
                if (rx.rx_valid && (rx.rx_data == SYNC_BYTE)) begin
                    next_state = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx.rx_valid) begin
                    next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (rx.rx_valid && (byte_idx == 2'd3)) begin
                    next_state = S_CHK;
                end
            end
            S_CHK: begin
                if (rx.rx_valid) begin
                    next_state = S_HUNT;
                    if ((rx.rx_data == xor_r) && addr_ok) begin
                        commit = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            default: begin
                next_state = S_HUNT;
            end
        endcase

        if (timeout) begin
            next_state = S_HUNT;
        end
    end

    // ------------------------------------------------------------------
    // Inter-byte gap timer: idle in HUNT, restarted by every byte.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (rx.rx_valid || (state == S_HUNT) || timeout) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame assembly: address latch, payload shift register, running XOR
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r   <= '0;
            data_buf <= '0;
            xor_r    <= '0;
            byte_idx <= '0;
        end else if (rx.rx_valid) begin
            case (state)
                S_ADDR: begin
                    addr_r   <= rx.rx_data;
                    xor_r    <= rx.rx_data;
                    byte_idx <= 2'd0;
                end
                S_DATA: begin
                    // D3 arrives first, so shifting left leaves it in the MSB.
                    data_buf <= {data_buf[23:0], rx.rx_data};
                    xor_r    <= xor_r ^ rx.rx_data;
                    byte_idx <= byte_idx + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Parameter register file and status strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per      <= 8'd10;
            p1wid    <= 16'd30;
            del      <= 16'd200;
            p2wid    <= 16'd60;
            nut_d    <= '0;
            nut_w    <= '0;
            pu       <= 1'b0;
            nut      <= 1'b0;
            bl       <= 1'b0;
            cp       <= '0;
            p_bl     <= '0;
            p_bl_off <= '0;
            rxd      <= 1'b0;
            err      <= 1'b0;
        end else begin
            rxd <= commit;
            err <= reject || timeout;
            if (commit) begin
                // Payload is truncated to the width of the target register.
                case (addr_r)
                    8'h01: per      <= data_buf[7:0];
                    8'h02: p1wid    <= data_buf[15:0];
                    8'h03: del      <= data_buf[15:0];
                    8'h04: p2wid    <= data_buf[15:0];
                    8'h05: nut_d    <= data_buf;
                    8'h06: nut_w    <= data_buf;
                    8'h07: begin
                        pu  <= data_buf[0];
                        nut <= data_buf[1];
                        bl  <= data_buf[2];
                    end
                    8'h08: cp       <= data_buf[7:0];
                    8'h09: p_bl     <= data_buf[7:0];
                    8'h0A: p_bl_off <= data_buf[15:0];
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_param_loader.sv
// -----------------------------------------------------------------------------
// tb_param_loader
//
// Self-checking bench for param_loader. Frames are issued by driver tasks;
// the frame-level reference model decides whether each frame commits or is
// rejected and pushes the expected event (kind + full register snapshot)
// into exp_q. A monitor pops and compares on every rxd/err strobe.
// -----------------------------------------------------------------------------
module tb_param_loader;

    localparam int T = 64;    // shortened gap timeout for simulation
    localparam int W = 156;   // {is_err, 155-bit register snapshot}

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    param_loader_if rx_if ();

    logic [7:0]  per;
    logic [15:0] p1wid, del, p2wid, p_bl_off;
    logic [31:0] nut_d, nut_w;
    logic        pu, nut, bl, rxd, err;
    logic [7:0]  cp, p_bl;
    logic [1:0]  state_dbg;

    param_loader #(
        .TIMEOUT_CYCLES (T),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx_if),
        .per       (per),
        .p1wid     (p1wid),
        .del       (del),
        .p2wid     (p2wid),
        .nut_d     (nut_d),
        .nut_w     (nut_w),
        .pu        (pu),
        .nut       (nut),
        .bl        (bl),
        .cp        (cp),
        .p_bl      (p_bl),
        .p_bl_off  (p_bl_off),
        .rxd       (rxd),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // ------------------------------------------------------------------
    // Reference model: a map from address to register contents
    // ------------------------------------------------------------------
    logic [7:0]  m_per, m_cp, m_p_bl;
    logic [15:0] m_p1wid, m_del, m_p2wid, m_p_bl_off;
    logic [31:0] m_nut_d, m_nut_w;
    logic        m_pu, m_nut, m_bl;

    logic [W-1:0] exp_q[$];
    int n_cmp   = 0;
    int n_err   = 0;
    int ev_count = 0;

    task automatic model_reset();
        m_per = 8'd10; m_p1wid = 16'd30; m_del = 16'd200; m_p2wid = 16'd60;
        m_nut_d = '0; m_nut_w = '0; m_pu = 0; m_nut = 0; m_bl = 0;
        m_cp = '0; m_p_bl = '0; m_p_bl_off = '0;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d);
        case (a)
            8'h01: m_per      = d[7:0];
            8'h02: m_p1wid    = d[15:0];
            8'h03: m_del      = d[15:0];
            8'h04: m_p2wid    = d[15:0];
            8'h05: m_nut_d    = d;
            8'h06: m_nut_w    = d;
            8'h07: begin m_pu = d[0]; m_nut = d[1]; m_bl = d[2]; end
            8'h08: m_cp       = d[7:0];
            8'h09: m_p_bl     = d[7:0];
            8'h0A: m_p_bl_off = d[15:0];
            default: ;
        endcase
    endtask

    function automatic logic [154:0] model_pack();
        return {m_per, m_p1wid, m_del, m_p2wid, m_nut_d, m_nut_w,
                m_pu, m_nut, m_bl, m_cp, m_p_bl, m_p_bl_off};
    endfunction

    function automatic logic [154:0] dut_pack();
        return {per, p1wid, del, p2wid, nut_d, nut_w,
                pu, nut, bl, cp, p_bl, p_bl_off};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks (entered and left on a negedge)
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b);
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        @(negedge clk);
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends a complete frame; the expected outcome is decided from the frame
    // contents and queued just before the CHK byte goes out.
    task automatic send_frame(input logic [7:0] a, input logic [31:0] d,
                              input logic [7:0] chk, input int gap_max);
        logic [7:0] b [7];
        logic [7:0] xr;
        bit good;
        b  = '{8'hA5, a, d[31:24], d[23:16], d[15:8], d[7:0], chk};
        xr = a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
        good = (chk == xr) && (a >= 8'h01) && (a <= 8'h0A);
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                if (good) begin
                    model_write(a, d);
                    exp_q.push_back({1'b0, model_pack()});
                end else begin
                    exp_q.push_back({1'b1, model_pack()});
                end
            end
            send_byte(b[i]);
            if (i < 6 && gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        check("drain_pending", W'(exp_q.size()), W'(0));
        exp_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Monitor: every rxd/err strobe must match the head of exp_q
    // ------------------------------------------------------------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && (rxd === 1'b1 || err === 1'b1)) begin
                ev_count++;
                check("rxd_err_exclusive", W'(rxd & err), W'(0));
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_event: got rxd=%0b err=%0b expected no strobe", rxd, err);
                end else begin
                    e = exp_q.pop_front();
                    check("event_is_err", W'(err), W'(e[W-1]));
                    check("event_regs", W'(dut_pack()), W'(e[154:0]));
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before timeout");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [7:0]  a, chk, junk;
        logic [31:0] d;
        int c0;
        bit seen;

        reset          = 1'b1;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        model_reset();
        idle(3);
        check("reset_regs", W'(dut_pack()), W'(model_pack()));
        check("reset_strobes", W'({rxd, err}), W'(0));
        reset = 1'b0;
        idle(2);

        // Good write to p1wid
        send_frame(8'h02, 32'h0000_012C, 8'h2F, 0);
        idle(3);
        // Bad checksum
        send_frame(8'h01, 32'h0000_0014, 8'h00, 1);
        idle(3);
        // Bad address with correct checksum
        send_frame(8'h0B, 32'h0000_0001, 8'h0A, 1);
        idle(3);
        drain();

        // Timeout: partial frame then silence
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h00);
        exp_q.push_back({1'b1, model_pack()});
        c0 = ev_count;
        repeat (T - 3) @(posedge clk);
        check("timeout_not_early", W'(ev_count), W'(c0));
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            if (ev_count > c0) begin
                seen = 1;
                break;
            end
        end
        check("timeout_err_seen", W'(seen), W'(1));
        @(negedge clk);
        send_frame(8'h03, 32'h0000_00C8, 8'hCB, 0);
        idle(3);
        drain();

        // Embedded sync value and back-to-back bytes
        send_byte(8'h00);
        send_frame(8'h07, 32'h0000_00A5, 8'hA2, 0);
        idle(3);
        drain();

        // A byte landing exactly on the expiry cycle keeps the frame alive
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h00);
        idle(T - 1);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h50);
        model_write(8'h04, 32'h0000_0050);
        exp_q.push_back({1'b0, model_pack()});
        send_byte(8'h54);
        idle(3);
        drain();

        // Randomized frames
        for (int n = 0; n < 60; n++) begin
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h00;
                send_byte(junk);
            end
            a = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(1, 10)) : 8'($urandom);
            d = $urandom;
            chk = a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
            if ($urandom_range(0, 99) < 15) chk = chk ^ 8'($urandom_range(1, 255));
            send_frame(a, d, chk, 3);
            idle($urandom_range(0, 3));
        end
        idle(3);
        drain();
        check("regs_after_random", W'(dut_pack()), W'(model_pack()));

        // Asynchronous reset in the middle of a frame
        send_frame(8'h01, 32'h0000_0077, 8'h76, 0);
        idle(2);
        drain();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h12);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_reset_regs", W'(dut_pack()), W'(model_pack()));
        check("async_reset_strobes", W'({rxd, err}), W'(0));
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        send_frame(8'h01, 32'h0000_0033, 8'h32, 0);
        idle(3);
        drain();
        check("final_regs", W'(dut_pack()), W'(model_pack()));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
